// File: rtl/satd_stream.sv
// Streaming SAD / Hadamard SATD over an N x N block, one row per accepted beat.
// SATD uses a horizontal row transform plus in-place vertical accumulation, then N drain cycles.
module satd_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] org,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH:0]   d,
  output logic [WIDTH-1:0] ad
);
  assign d  = {1'b0, org} - {1'b0, cur};
  assign ad = (org >= cur) ? org - cur : cur - org;
endmodule

module satd_stream #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int LOG2N = $clog2(N),
  localparam int RES_W = WIDTH + 4*LOG2N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH*N-1:0] ORG,
  input  logic [WIDTH*N-1:0] CUR,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   result,
  output logic               busy
);
  localparam int DW = WIDTH + 1;
  localparam int HW = WIDTH + 1 + LOG2N;
  localparam int CW = WIDTH + 1 + 2*LOG2N;

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t state, state_d;
  logic [LOG2N-1:0] row_cnt, drn_cnt;
  logic             mode_q, cur_mode, accept, last_row;
  logic [RES_W-1:0] acc, row_sad, col_sum;

  logic [N-1:0][DW-1:0]         d;
  logic [N-1:0][WIDTH-1:0]      ad;
  logic [N-1:0][HW-1:0]         h;
  logic [N-1:0][N-1:0][CW-1:0]  c, vt;
  logic [CW-1:0]                hx, cv, mag;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    satd_lane #(.WIDTH(WIDTH)) u_lane (
      .org (ORG[gi*WIDTH +: WIDTH]),
      .cur (CUR[gi*WIDTH +: WIDTH]),
      .d   (d[gi]),
      .ad  (ad[gi])
    );
  end

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = !rst && ((state != ACCUM) || (row_cnt != '0));
  assign result    = acc;
  assign accept    = in_valid && in_ready;
  assign last_row  = (row_cnt == LOG2N'(N-1));
  // Mode is taken live on row 0 and from the latch for the rest of the block.
  assign cur_mode  = (row_cnt == '0) ? mode : mode_q;

  always_comb begin
    row_sad = '0;
    h       = '0;
    for (int i = 0; i < N; i++) row_sad = row_sad + RES_W'(ad[i]);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (^(LOG2N'(k) & LOG2N'(i))) h[k] = h[k] - HW'($signed(d[i]));
        else                          h[k] = h[k] + HW'($signed(d[i]));
  end

  // Vertical butterfly folded into accumulation: row r contributes H[j][r]*h[k] to c[k][j].
  always_comb begin
    vt = '0;
    hx = '0;
    for (int k = 0; k < N; k++) begin
      hx = CW'($signed(h[k]));
      for (int j = 0; j < N; j++)
        vt[k][j] = (^(LOG2N'(j) & row_cnt)) ? -hx : hx;
    end
  end

  always_comb begin
    col_sum = '0;
    cv      = '0;
    mag     = '0;
    for (int j = 0; j < N; j++) begin
      cv      = c[drn_cnt][j];
      mag     = cv[CW-1] ? -cv : cv;
      col_sum = col_sum + RES_W'(mag);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ACCUM:   if (accept && last_row) state_d = cur_mode ? DRAIN : DONE;
      DRAIN:   if (drn_cnt == LOG2N'(N-1)) state_d = DONE;
      DONE:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      drn_cnt <= '0;
      mode_q  <= 1'b0;
      acc     <= '0;
      c       <= '0;
    end else begin
      if (accept) begin
        row_cnt <= row_cnt + 1'b1;
        if (row_cnt == '0) mode_q <= mode;
        if (!cur_mode) acc <= acc + row_sad;
        else
          for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
              c[k][j] <= c[k][j] + vt[k][j];
      end
      if (state == DRAIN) begin
        acc     <= acc + col_sum;
        drn_cnt <= drn_cnt + 1'b1;
      end
      if (state == DONE && out_ready) begin
        acc     <= '0;
        c       <= '0;
        row_cnt <= '0;
        drn_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_satd_stream.sv
// Directed bench for satd_stream (WIDTH=8, N=4) with hand-computed block metrics.
module tb_satd_stream;
  logic        clk = 1'b0;
  logic        rst, mode, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] ORG, CUR;
  logic [15:0] result;
  int checks = 0;
  int errors = 0;

  satd_stream #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .ORG(ORG), .CUR(CUR), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_row(input logic [31:0] o, input logic [31:0] c, input logic m);
    ORG = o; CUR = c; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] o, input logic [31:0] c, input logic m);
    for (int r = 0; r < 4; r++) send_row(o, c, m);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ORG = '0; CUR = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0; #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // SAD, uniform d=3: 16*3
    send_row(32'h0A0A0A0A, 32'h07070707, 1'b0);
    check("sad_busy_row0", 32'(busy), 32'd1);
    send_row(32'h0A0A0A0A, 32'h07070707, 1'b0);
    send_row(32'h0A0A0A0A, 32'h07070707, 1'b0);
    send_row(32'h0A0A0A0A, 32'h07070707, 1'b0);
    check("sad_dc_latency", 32'(out_valid), 32'd1);
    check("sad_dc_result", 32'(result), 32'd48);
    ack();
    check("sad_ack_valid", 32'(out_valid), 32'd0);
    check("sad_ack_in_ready", 32'(in_ready), 32'd1);
    check("sad_ack_busy", 32'(busy), 32'd0);

    // SATD, uniform d=3: DC term 48, DONE 4 edges after the accept edge
    send_block(32'h0A0A0A0A, 32'h07070707, 1'b1);
    check("satd_dc_drain_v", 32'(out_valid), 32'd0);
    check("satd_dc_drain_b", 32'(busy), 32'd1);
    check("satd_dc_drain_r", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("satd_dc_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("satd_dc_latency", 32'(out_valid), 32'd1);
    check("satd_dc_result", 32'(result), 32'd48);
    ack();

    // Impulse d[0][0]=5
    send_row(32'h00000005, 32'h0, 1'b0);
    send_row(32'h0, 32'h0, 1'b0);
    send_row(32'h0, 32'h0, 1'b0);
    send_row(32'h0, 32'h0, 1'b0);
    check("sad_imp_valid", 32'(out_valid), 32'd1);
    check("sad_imp_result", 32'(result), 32'd5);
    ack();
    send_row(32'h00000005, 32'h0, 1'b1);
    send_row(32'h0, 32'h0, 1'b1);
    send_row(32'h0, 32'h0, 1'b1);
    send_row(32'h0, 32'h0, 1'b1);
    wait_done("satd_imp_done");
    check("satd_imp_result", 32'(result), 32'd80);
    ack();

    // Checkerboard d=(-1)^(r+i)
    for (int r = 0; r < 4; r++)
      if (r % 2 == 0) send_row(32'h0A0B0A0B, 32'h0B0A0B0A, 1'b1);
      else            send_row(32'h0B0A0B0A, 32'h0A0B0A0B, 1'b1);
    wait_done("satd_chk_done");
    check("satd_chk_result", 32'(result), 32'd16);
    ack();
    for (int r = 0; r < 4; r++)
      if (r % 2 == 0) send_row(32'h0A0B0A0B, 32'h0B0A0B0A, 1'b0);
      else            send_row(32'h0B0A0B0A, 32'h0A0B0A0B, 1'b0);
    check("sad_chk_valid", 32'(out_valid), 32'd1);
    check("sad_chk_result", 32'(result), 32'd16);
    ack();

    // Max-magnitude SATD, then hold in DONE with stray in_valid
    send_block(32'hFFFFFFFF, 32'h0, 1'b1);
    wait_done("satd_max_done");
    check("satd_max_result", 32'(result), 32'd4080);
    ORG = 32'h12345678; CUR = 32'h0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_result", 32'(result), 32'd4080);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    ack();
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_result", 32'(result), 32'd0);

    // Reset after 2 rows; mode toggles on rows 1..3 must not matter
    send_row(32'hFFFFFFFF, 32'h0, 1'b1);
    send_row(32'hFFFFFFFF, 32'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    send_row(32'h55555555, 32'h55555555, 1'b1);
    send_row(32'h55555555, 32'h55555555, 1'b0);
    send_row(32'h55555555, 32'h55555555, 1'b1);
    send_row(32'h55555555, 32'h55555555, 1'b0);
    check("latch_satd_not_done", 32'(out_valid), 32'd0);
    wait_done("latch_satd_done");
    check("latch_satd_result", 32'(result), 32'd0);
    ack();
    send_row(32'h55555555, 32'h55555555, 1'b0);
    send_row(32'h55555555, 32'h55555555, 1'b1);
    send_row(32'h55555555, 32'h55555555, 1'b0);
    send_row(32'h55555555, 32'h55555555, 1'b1);
    check("latch_sad_valid", 32'(out_valid), 32'd1);
    check("latch_sad_result", 32'(result), 32'd0);
    ack();

    // Reset during DRAIN discards the block
    send_block(32'hFFFFFFFF, 32'h0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("drnrst_in_ready", 32'(in_ready), 32'd1);
    send_block(32'h0A0A0A0A, 32'h07070707, 1'b0);
    check("drnrst_valid", 32'(out_valid), 32'd1);
    check("drnrst_result", 32'(result), 32'd48);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
